conv_kernel_pos_gen: RTL and testbench

CONV_KERNEL_POS_GEN -- requirements
Module: conv_kernel_pos_gen

---
 rtl/conv_kernel_pos_gen_if.sv | 34 +++
 rtl/conv_kernel_pos_gen.sv | 102 ++++++++++
 tb/tb_conv_kernel_pos_gen.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_kernel_pos_gen_if.sv
// Kernel boundary-flag type plus the pixel-in and flagged-pixel-out
// valid/ready stream interfaces used by conv_kernel_pos_gen.
package conv_pkg;
    typedef struct packed {
        logic n1;
        logic n2;
        logic s1;
        logic s2;
        logic w1;
        logic w2;
        logic e1;
        logic e2;
    } kernel_pos_t;
endpackage

interface conv_in_if;
    logic vld;
    logic sof;
    logic rdy;
    modport master (output vld, sof, input rdy);
    modport slave  (input vld, sof, output rdy);
endinterface

interface conv_out_if;
    import conv_pkg::*;
    logic        vld;
    logic        rdy;
    logic        sof;
    logic        eol;
    logic        eof;
    kernel_pos_t pos;
    modport master (output vld, sof, eol, eof, pos, input rdy);
    modport slave  (input vld, sof, eol, eof, pos, output rdy);
endinterface

// File: rtl/conv_kernel_pos_gen.sv
// Tags each raster-order kernel-centre pixel with image-border flags and
// frame markers; one registered stage with frame-sync checking.
module conv_kernel_pos_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic        clk,
    input  logic        rst,
    conv_in_if.slave    in_if,
    conv_out_if.master  out_if,
    output logic        err_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] CM2  = CW'(IMG_W - 2);
    localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
    localparam logic [RW-1:0] RM2  = RW'(IMG_H - 2);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e      state_q;
    logic [CW-1:0] col_q, col_d, col_b;
    logic [RW-1:0] row_q, row_d, row_b;
    logic        out_vld_q;
    logic        err_q;
    kernel_pos_t pos_q, pos_d;
    logic        sof_q, eol_q, eof_q;
    logic        sof_d, eol_d, eof_d;
    logic        acc, drop, emit, resync;

    assign in_if.rdy = ~rst & (~out_vld_q | out_if.rdy);
    assign acc       = in_if.vld & in_if.rdy;
    assign drop      = acc & (state_q == IDLE) & ~in_if.sof;
    assign emit      = acc & ~drop;
    assign resync    = acc & in_if.sof & (state_q == ACTIVE)
                     & ((col_q != '0) | (row_q != '0));

    // An sof beat always re-anchors the frame at (0,0).
    always_comb begin
        col_b    = in_if.sof ? '0 : col_q;
        row_b    = in_if.sof ? '0 : row_q;
        pos_d    = '0;
        pos_d.n2 = (row_b == '0);
        pos_d.n1 = (row_b == RW'(1));
        pos_d.s1 = (row_b == RM2);
        pos_d.s2 = (row_b == RMAX);
        pos_d.w2 = (col_b == '0);
        pos_d.w1 = (col_b == CW'(1));
        pos_d.e1 = (col_b == CM2);
        pos_d.e2 = (col_b == CMAX);
        sof_d    = (col_b == '0) & (row_b == '0);
        eol_d    = (col_b == CMAX);
        eof_d    = eol_d & (row_b == RMAX);
        col_d    = col_b + CW'(1);
        row_d    = row_b;
        if (col_b == CMAX) begin
            col_d = '0;
            row_d = (row_b == RMAX) ? '0 : row_b + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            out_vld_q <= 1'b0;
            pos_q     <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (emit) begin
                col_q     <= col_d;
                row_q     <= row_d;
                pos_q     <= pos_d;
                sof_q     <= sof_d;
                eol_q     <= eol_d;
                eof_q     <= eof_d;
                out_vld_q <= 1'b1;
                state_q   <= eof_d ? IDLE : ACTIVE;
            end else if (out_if.rdy) begin
                out_vld_q <= 1'b0;
            end
            if (drop | resync) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_if.vld = out_vld_q;
    assign out_if.pos = pos_q;
    assign out_if.sof = sof_q;
    assign out_if.eol = eol_q;
    assign out_if.eof = eof_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_conv_kernel_pos_gen.sv
// Randomised bench for conv_kernel_pos_gen against a frame-index model
// on a 5x5 image.
module tb_conv_kernel_pos_gen;
  import conv_pkg::*;

  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  conv_in_if  in_if();
  conv_out_if out_if();

  conv_kernel_pos_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_if (in_if),
    .out_if(out_if),
    .err_o (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] pos;
    logic [2:0] mk;
  } obs_t;

  typedef struct {
    logic [7:0] pos;
    logic [2:0] mk;
  } exp_t;

  obs_t got[$];
  exp_t exp_q[$];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int rmode = 0;
  int first_acc = -1;

  bit m_act;
  int m_idx;
  bit m_err;

  logic       s_in_rdy, s_out_vld, s_acc, s_r;
  logic [7:0] s_pos;
  logic [2:0] s_mk;

  // Flags {n1,n2,s1,s2,w1,w2,e1,e2} and markers {sof,eol,eof}
  // straight from the linear frame index.
  function automatic exp_t ref_pos(int idx);
    int c = idx % W;
    int r = idx / W;
    exp_t e;
    e.pos = {r == 1, r == 0, r == H - 2, r == H - 1,
             c == 1, c == 0, c == W - 2, c == W - 1};
    e.mk = {idx == 0, c == W - 1, idx == N - 1};
    return e;
  endfunction

  task automatic model_beat(input bit s);
    if (!m_act && !s) begin
      m_err = 1'b1;
      return;
    end
    if (s) begin
      if (m_act) m_err = 1'b1;
      m_idx = 0;
    end
    exp_q.push_back(ref_pos(m_idx));
    m_idx++;
    m_act = 1'b1;
    if (m_idx == N) begin
      m_idx = 0;
      m_act = 1'b0;
    end
  endtask

  task automatic mdl_clear();
    got.delete();
    exp_q.delete();
    m_act = 0;
    m_idx = 0;
    m_err = 0;
    first_acc = -1;
  endtask

  task automatic step(input bit v, input bit s);
    logic r;
    case (rmode)
      1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      2: r = ($urandom % 3) != 0;
      3: r = 1'b0;
      default: r = 1'b1;
    endcase
    @(negedge clk);
    in_if.vld = v;
    in_if.sof = s;
    out_if.rdy = r;
    #1;
    s_r = r;
    s_in_rdy = in_if.rdy;
    s_out_vld = out_if.vld;
    s_pos = out_if.pos;
    s_mk = {out_if.sof, out_if.eol, out_if.eof};
    s_acc = v && in_if.rdy;
    if (out_if.vld && r) got.push_back('{cyc, s_pos, s_mk});
    if (s_acc) begin
      if (first_acc < 0) first_acc = cyc;
      model_beat(s);
    end
    cyc++;
  endtask

  task automatic send_beat(input bit s);
    int k = 0;
    s_acc = 0;
    while (!s_acc && k < 50) begin
      step(1'b1, s);
      k++;
    end
    if (!s_acc) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout accepted=0 required=1");
    end
  endtask

  task automatic drain();
    int k = 0;
    rmode = 0;
    s_out_vld = 1'b1;
    while (s_out_vld && k < 20) begin
      step(1'b0, 1'b0);
      k++;
    end
    nvec++;
    if (s_out_vld) begin
      nerr++;
      $display("FAIL drain_timeout out_vld=1 required=0");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_if.vld = 0;
    in_if.sof = 0;
    out_if.rdy = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_clear();
  endtask

  task automatic test_reset();
    in_if.vld = 0;
    in_if.sof = 0;
    out_if.rdy = 1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if (out_if.vld !== 1'b0 || in_if.rdy !== 1'b0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctrl vld/rdy/err=%b%b%b required=000",
               out_if.vld, in_if.rdy, err);
    end
    nvec++;
    if ({out_if.pos, out_if.sof, out_if.eol, out_if.eof} !== 11'd0) begin
      nerr++;
      $display("FAIL reset_data pos=%b mk=%b%b%b required=0",
               out_if.pos, out_if.sof, out_if.eol, out_if.eof);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (in_if.rdy !== 1'b1) begin
      nerr++;
      $display("FAIL reset_rdy in_rdy=%b required=1", in_if.rdy);
    end
    mdl_clear();
  endtask

  task automatic test_full_frame();
    do_reset();
    rmode = 0;
    for (int i = 0; i < N; i++) send_beat(i == 0);
    drain();
    nvec++;
    if (got.size() != N || exp_q.size() != N) begin
      nerr++;
      $display("FAIL frame_count got=%0d model=%0d required=%0d",
               got.size(), exp_q.size(), N);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk ||
          got[i].cyc !== got[0].cyc + i) begin
        nerr++;
        $display("FAIL frame_beat%0d pos=%b mk=%b cyc=%0d required %b %b %0d",
                 i, got[i].pos, got[i].mk, got[i].cyc,
                 exp_q[i].pos, exp_q[i].mk, got[0].cyc + i);
      end
    end
    if (got.size() == N) begin
      nvec++;
      if (got[0].cyc !== first_acc + 1) begin
        nerr++;
        $display("FAIL latency out_cyc=%0d required=%0d",
                 got[0].cyc, first_acc + 1);
      end
      nvec++;
      if (got[0].pos !== 8'b0100_0100 || got[0].mk !== 3'b100) begin
        nerr++;
        $display("FAIL beat0 pos=%b mk=%b required 01000100 100",
                 got[0].pos, got[0].mk);
      end
      nvec++;
      if (got[6].pos !== 8'b1000_1000 || got[6].mk !== 3'b000) begin
        nerr++;
        $display("FAIL beat6 pos=%b mk=%b required 10001000 000",
                 got[6].pos, got[6].mk);
      end
      nvec++;
      if (got[12].pos !== 8'b0 || got[12].mk !== 3'b000) begin
        nerr++;
        $display("FAIL beat12 pos=%b mk=%b required 0 000",
                 got[12].pos, got[12].mk);
      end
      nvec++;
      if (got[24].pos !== 8'b0001_0001 || got[24].mk !== 3'b011) begin
        nerr++;
        $display("FAIL beat24 pos=%b mk=%b required 00010001 011",
                 got[24].pos, got[24].mk);
      end
    end
    nvec++;
    if (err !== 1'b0) begin
      nerr++;
      $display("FAIL frame_err err=%b required=0", err);
    end
  endtask

  task automatic test_stall();
    bit         hold;
    logic [7:0] hp;
    logic [2:0] hm;
    do_reset();
    rmode = 1;
    for (int b = 0; b < N; b++) begin
      int k = 0;
      s_acc = 0;
      while (!s_acc && k < 50) begin
        hold = s_out_vld && !s_r;
        hp = s_pos;
        hm = s_mk;
        step(1'b1, b == 0);
        k++;
        if (hold) begin
          nvec++;
          if (s_out_vld !== 1'b1 || s_pos !== hp || s_mk !== hm) begin
            nerr++;
            $display("FAIL stall_hold vld=%b pos=%b mk=%b required 1 %b %b",
                     s_out_vld, s_pos, s_mk, hp, hm);
          end
        end
        if (s_out_vld && !s_r) begin
          nvec++;
          if (s_in_rdy !== 1'b0) begin
            nerr++;
            $display("FAIL stall_rdy in_rdy=%b required=0", s_in_rdy);
          end
        end
      end
    end
    drain();
    nvec++;
    if (got.size() != exp_q.size() || got.size() != N) begin
      nerr++;
      $display("FAIL stall_count got=%0d required=%0d", got.size(), N);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk) begin
        nerr++;
        $display("FAIL stall_beat%0d pos=%b mk=%b required %b %b",
                 i, got[i].pos, got[i].mk, exp_q[i].pos, exp_q[i].mk);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rmode = 0;
    for (int i = 0; i < 2 * N; i++) send_beat(i % N == 0);
    drain();
    nvec++;
    if (got.size() != 2 * N || exp_q.size() != 2 * N) begin
      nerr++;
      $display("FAIL b2b_count got=%0d required=%0d", got.size(), 2 * N);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk ||
          got[i].cyc !== got[0].cyc + i) begin
        nerr++;
        $display("FAIL b2b_beat%0d pos=%b mk=%b cyc=%0d required %b %b %0d",
                 i, got[i].pos, got[i].mk, got[i].cyc,
                 exp_q[i].pos, exp_q[i].mk, got[0].cyc + i);
      end
    end
    if (got.size() == 2 * N) begin
      nvec++;
      if (got[N-1].mk[0] !== 1'b1 || got[N].mk[2] !== 1'b1) begin
        nerr++;
        $display("FAIL b2b_seam eof=%b sof=%b required 1 1",
                 got[N-1].mk[0], got[N].mk[2]);
      end
    end
    nvec++;
    if (err !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_err err=%b required=0", err);
    end
  endtask

  task automatic test_resync();
    do_reset();
    rmode = 0;
    for (int i = 0; i < 8 + N - 1; i++) send_beat(i == 0 || i == 7);
    drain();
    nvec++;
    if (got.size() != 8 + N - 1 || exp_q.size() != got.size()) begin
      nerr++;
      $display("FAIL resync_count got=%0d required=%0d", got.size(), 8 + N - 1);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk) begin
        nerr++;
        $display("FAIL resync_beat%0d pos=%b mk=%b required %b %b",
                 i, got[i].pos, got[i].mk, exp_q[i].pos, exp_q[i].mk);
      end
    end
    if (got.size() == 8 + N - 1) begin
      nvec++;
      if (got[7].mk[2] !== 1'b1 || got[7].pos[6] !== 1'b1 ||
          got[7].pos[2] !== 1'b1 || got[31].mk[0] !== 1'b1) begin
        nerr++;
        $display("FAIL resync_marks b7 pos=%b mk=%b last mk=%b required sof,n2,w2 then eof",
                 got[7].pos, got[7].mk, got[31].mk);
      end
    end
    nvec++;
    if (err !== 1'b1) begin
      nerr++;
      $display("FAIL resync_err err=%b required=1", err);
    end
  endtask

  task automatic test_drop();
    do_reset();
    rmode = 0;
    send_beat(1'b0);
    repeat (2) begin
      step(1'b0, 1'b0);
      nvec++;
      if (s_out_vld !== 1'b0) begin
        nerr++;
        $display("FAIL drop_vld out_vld=%b required=0", s_out_vld);
      end
    end
    nvec++;
    if (err !== 1'b1) begin
      nerr++;
      $display("FAIL drop_err err=%b required=1", err);
    end
    for (int i = 0; i < N; i++) send_beat(i == 0);
    drain();
    nvec++;
    if (got.size() != N || exp_q.size() != N) begin
      nerr++;
      $display("FAIL drop_count got=%0d required=%0d", got.size(), N);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk) begin
        nerr++;
        $display("FAIL drop_beat%0d pos=%b mk=%b required %b %b",
                 i, got[i].pos, got[i].mk, exp_q[i].pos, exp_q[i].mk);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    rmode = 0;
    for (int i = 0; i < 10; i++) send_beat(i == 0);
    rmode = 3;
    step(1'b1, 1'b0);
    nvec++;
    if (s_out_vld !== 1'b1 || s_in_rdy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_hold vld=%b in_rdy=%b required 1 0",
               s_out_vld, s_in_rdy);
    end
    @(negedge clk);
    rst = 1'b1;
    in_if.vld = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if (out_if.vld !== 1'b0 || err !== 1'b0 || in_if.rdy !== 1'b1) begin
      nerr++;
      $display("FAIL mid_rst vld=%b err=%b in_rdy=%b required 0 0 1",
               out_if.vld, err, in_if.rdy);
    end
    mdl_clear();
    rmode = 0;
    for (int i = 0; i < N; i++) send_beat(i == 0);
    drain();
    nvec++;
    if (got.size() != N || exp_q.size() != N) begin
      nerr++;
      $display("FAIL mid_count got=%0d required=%0d", got.size(), N);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk) begin
        nerr++;
        $display("FAIL mid_beat%0d pos=%b mk=%b required %b %b",
                 i, got[i].pos, got[i].mk, exp_q[i].pos, exp_q[i].mk);
      end
    end
    nvec++;
    if (err !== 1'b0) begin
      nerr++;
      $display("FAIL mid_err err=%b required=0", err);
    end
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    rmode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) step(1'b0, 1'b0);
      rmode = 2;
      if (!m_act) s = ($urandom % 6) != 0;
      else s = ($urandom % 40) == 0;
      send_beat(s);
    end
    drain();
    nvec++;
    if (got.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL rand_count got=%0d required=%0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got[i].pos !== exp_q[i].pos || got[i].mk !== exp_q[i].mk) begin
        nerr++;
        $display("FAIL rand_beat%0d pos=%b mk=%b required %b %b",
                 i, got[i].pos, got[i].mk, exp_q[i].pos, exp_q[i].mk);
      end
    end
    nvec++;
    if (err !== m_err) begin
      nerr++;
      $display("FAIL rand_err err=%b required=%b", err, m_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.vld = 0;
    in_if.sof = 0;
    out_if.rdy = 0;
    s_out_vld = 0;
    s_r = 1;
    test_reset();
    test_full_frame();
    test_stall();
    test_back_to_back();
    test_resync();
    test_drop();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
